ctrl_decode_ex: RTL and testbench
=================================

Name: ctrl_decode_ex

Overview:
- Registered successor to the combinational EX-stage control decoder.
- Decodes the ID-stage MIPS instruction into the EX control bundle, then registers it with a valid bit.
- Applies stall/flush and an internal HI/LO interlock that tracks multi-cycle multiply (and optionally divide) occupancy.
- Sits between the instruction register and the EX datapath; it raises stall_req back to fetch.

Parameters:
- MUL_LAT, 4: cycles a mult/multu occupies HI/LO (legal range 1..15).
- DIV_LAT, 32: cycles a div/divu occupies HI/LO (legal range 1..63); used only with CTRL_DIV_EN.
- CNT_W, 6: width of the occupancy counter; must satisfy 2**CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr_ID  in  32  instruction in ID
- valid_ID  in  1  instr_ID is real
- stall_in  in  1  downstream hold; EX register keeps its value
- flush_in  in  1  kill; EX register becomes a bubble
- alu_op_EX  out  4  ALU opcode
- shamt_EX  out  5  shift amount
- enhilo_EX  out  1  HI/LO write enable (mult/div)
- regsel_EX  out  2  writeback select: 0 ALU, 1 HI, 2 LO
- regwrite_EX  out  1  register-file write
- rdrt_EX  out  1  destination select: 1 rt, 0 rd
- memwrite_EX  out  1  memory write
- alu_src_EX  out  2  B operand: 0 rt, 1 sign-extended imm, 2 zero-extended imm, 3 imm<<16
- gpio_out_EX  out  1  GPIO write (srl, shamt 0)
- gpio_in_EX  out  1  GPIO read (sra, shamt 0)
- illegal_EX  out  1  unsupported opcode/funct
- valid_EX  out  1  EX bundle is live
- hilo_busy  out  1  occupancy counter != 0
- stall_req  out  1  ID must hold (HI/LO hazard)

Behaviour:
- Reset: every output is 0, the counter is 0, and the FSM is IDLE.
- A bubble is the all-zero bundle with valid_EX=0.
- Outputs never carry X; fields that don't matter are driven 0.
- Latency: decode is combinational; results appear at the EX outputs one clock after capture.
- EX register update priority, per clock:
  1. flush_in: load bubble.
  2. stall_in: hold.
  3. stall_req: load bubble.
  4. valid_ID: load decode(instr_ID).
  5. Otherwise: load bubble.
- ALU opcode encodings: AND 0000, OR 0001, NOR 0010, XOR 0011, ADD/ADDU 0100, SUB/SUBU 0101, MULT 0110, MULTU 0111, SLL/MFHI/MFLO 1000, SRL 1001, SRA 1010, SLT 1100, SLTU 1101, DIV 1110, DIVU 1111.
- R-type instructions: rdrt=0, alu_src=0, regwrite=1, except the following.
  - mult/multu/div/divu: regwrite=0, enhilo=1.
  - mfhi: regsel=1. mflo: regsel=2.
  - sll/srl/sra with shamt!=0: shamt_EX=instr[10:6].
  - srl with shamt 0: gpio_out=1, regwrite=0. sra with shamt 0: gpio_in=1, regwrite=1.
- instr_ID==0 (NOP): valid_EX=1, all control fields 0.
- I-type instructions: rdrt=1, regwrite=1.
  - addi/addiu: ADD, alu_src=1.
  - andi/ori/xori: AND/OR/XOR, alu_src=2.
  - slti: SLT, alu_src=1.
  - lui: SLL, shamt 16, alu_src=3. memwrite=0 for all instructions in this generation.
- Anything else: illegal_EX=1, regwrite=0, enhilo=0.
- Interlock FSM has two states, IDLE and BUSY:
  - A mult/multu loaded into EX (not held by stall_in, not flushed) sets cnt=MUL_LAT and enters BUSY.
  - In BUSY, cnt decrements each clock; it returns to IDLE when cnt reaches 1 → 0.
  - hilo_busy = (cnt != 0).
- stall_req = hilo_busy && valid_ID && instr_ID is one of mfhi, mflo, mult, multu, div, div.
  - stall_req is combinational and drops in the cycle cnt becomes 0.
- A flush in the capture cycle of a mult cancels its counter load. Flushes while BUSY do not clear the counter, because HI/LO are already being written.
- MUL_LAT=1: the counter is loaded with 1; one hazard cycle.
- An asynchronous rst mid-BUSY clears the counter and bundle immediately.

Optional Feature:
- CTRL_DIV_EN defined:
  - funct 011010/011011 decode to DIV/DIVU (alu_op 1110/1111, enhilo=1).
  - They load cnt=DIV_LAT.
- Undefined:
  - These functs are illegal (illegal_EX=1, enhilo=0) and never start the counter.
  - DIV_LAT is unused.

Decomposition:
- Package ctrl_pkg holds:
  - opcode/funct localparams;
  - an alu_op enum;
  - an alu_src enum;
  - a regsel enum;
  - a packed ctrl_bundle_t struct;
  - a CTRL_BUBBLE constant.
- Sub-module ctrl_decode: pure combinational instr → ctrl_bundle_t + is_muldiv/is_hilo_read flags.
- The top holds the EX register, the counter/FSM and stall logic.

Test Plan:
1. Reset: rst=1 asynchronously mid-cycle → all outputs 0 immediately; after release, a NOP gives valid_EX=1 and regwrite_EX=0.
2. Decode sweep:
   - addi 0x20010005 → alu_op 0100, alu_src 1, rdrt 1, regwrite 1.
   - lui 0x3C01ABCD → alu_op 1000, shamt 16, alu_src 3.
   - srl shamt 0 → gpio_out 1.
   - opcode 0x3F → illegal_EX=1.
3. Interlock, MUL_LAT=4: mult then an immediate mflo → stall_req high for 4 cycles; 4 bubbles reach EX; mflo is issued with regsel=2.
4. stall_in held 3 cycles with an add in EX → outputs unchanged for 3 cycles. A simultaneous flush_in → bubble (flush wins).
5. Flush in the mult capture cycle → hilo_busy stays 0; a following mfhi has no stall.
6. Divide, DIV_LAT=32: with CTRL_DIV_EN, div then mfhi → 32 stall cycles. Without the macro, div → illegal_EX=1 and hilo_busy=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the registered EX-stage control decoder.
package ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type function codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_NOR   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_ADD   = 4'b0100,
    ALU_SUB   = 4'b0101,
    ALU_MULT  = 4'b0110,
    ALU_MULTU = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1100,
    ALU_SLTU  = 4'b1101,
    ALU_DIV   = 4'b1110,
    ALU_DIVU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RT   = 2'd0,
    SRC_SIMM = 2'd1,
    SRC_ZIMM = 2'd2,
    SRC_LUI  = 2'd3
  } alu_src_e;

  typedef enum logic [1:0] {
    SEL_ALU = 2'd0,
    SEL_HI  = 2'd1,
    SEL_LO  = 2'd2
  } regsel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hilo_state_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic [4:0] shamt;
    logic     enhilo;
    regsel_e  regsel;
    logic     regwrite;
    logic     rdrt;
    logic     memwrite;
    alu_src_e alu_src;
    logic     gpio_out;
    logic     gpio_in;
    logic     illegal;
    logic     valid;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction -> EX control bundle decoder.
// CTRL_DIV_EN: when defined, div/divu decode as HI/LO operations;
// otherwise they are reported as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         is_muldiv,
  output logic         is_hilo_read
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign shamt  = instr[10:6];

  // Field decode; every field not set below stays at its bubble value.
  always_comb begin
    ctrl         = CTRL_BUBBLE;
    is_muldiv    = 1'b0;
    is_hilo_read = 1'b0;
    ctrl.valid   = 1'b1;
    if (instr != '0) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.regwrite = 1'b1;
          case (funct)
            FN_AND:           ctrl.alu_op = ALU_AND;
            FN_OR:            ctrl.alu_op = ALU_OR;
            FN_NOR:           ctrl.alu_op = ALU_NOR;
            FN_XOR:           ctrl.alu_op = ALU_XOR;
            FN_ADD, FN_ADDU:  ctrl.alu_op = ALU_ADD;
            FN_SUB, FN_SUBU:  ctrl.alu_op = ALU_SUB;
            FN_SLT:           ctrl.alu_op = ALU_SLT;
            FN_SLTU:          ctrl.alu_op = ALU_SLTU;
            FN_MULT, FN_MULTU: begin
              ctrl.alu_op   = (funct == FN_MULT) ? ALU_MULT : ALU_MULTU;
              ctrl.regwrite = 1'b0;
              ctrl.enhilo   = 1'b1;
              is_muldiv     = 1'b1;
            end
`ifdef CTRL_DIV_EN
            FN_DIV, FN_DIVU: begin
              ctrl.alu_op   = (funct == FN_DIV) ? ALU_DIV : ALU_DIVU;
              ctrl.regwrite = 1'b0;
              ctrl.enhilo   = 1'b1;
              is_muldiv     = 1'b1;
            end
`else
            FN_DIV, FN_DIVU: begin
              ctrl.regwrite = 1'b0;
              ctrl.illegal  = 1'b1;
            end
`endif
            FN_MFHI, FN_MFLO: begin
              ctrl.alu_op  = ALU_SLL;
              ctrl.regsel  = (funct == FN_MFHI) ? SEL_HI : SEL_LO;
              is_hilo_read = 1'b1;
            end
            FN_SLL: begin
              ctrl.alu_op = ALU_SLL;
              ctrl.shamt  = shamt;
            end
            // srl/sra with a zero shift are repurposed as GPIO write/read.
            FN_SRL: begin
              ctrl.alu_op = ALU_SRL;
              ctrl.shamt  = shamt;
              if (shamt == '0) begin
                ctrl.gpio_out = 1'b1;
                ctrl.regwrite = 1'b0;
              end
            end
            FN_SRA: begin
              ctrl.alu_op = ALU_SRA;
              ctrl.shamt  = shamt;
              if (shamt == '0) ctrl.gpio_in = 1'b1;
            end
            default: begin
              ctrl.regwrite = 1'b0;
              ctrl.illegal  = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          ctrl.alu_op = ALU_ADD; ctrl.alu_src = SRC_SIMM;
          ctrl.rdrt = 1'b1; ctrl.regwrite = 1'b1;
        end
        OP_SLTI: begin
          ctrl.alu_op = ALU_SLT; ctrl.alu_src = SRC_SIMM;
          ctrl.rdrt = 1'b1; ctrl.regwrite = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          ctrl.alu_op  = (opcode == OP_ANDI) ? ALU_AND :
                         (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
          ctrl.alu_src = SRC_ZIMM;
          ctrl.rdrt = 1'b1; ctrl.regwrite = 1'b1;
        end
        OP_LUI: begin
          ctrl.alu_op = ALU_SLL; ctrl.shamt = 5'd16; ctrl.alu_src = SRC_LUI;
          ctrl.rdrt = 1'b1; ctrl.regwrite = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decode_ex.sv
// Registered EX-stage control decoder with stall/flush and HI/LO interlock.
// CTRL_DIV_EN: enables div/divu decode and the DIV_LAT occupancy load.
module ctrl_decode_ex
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ID,
  input  logic        valid_ID,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [3:0]  alu_op_EX,
  output logic [4:0]  shamt_EX,
  output logic        enhilo_EX,
  output logic [1:0]  regsel_EX,
  output logic        regwrite_EX,
  output logic        rdrt_EX,
  output logic        memwrite_EX,
  output logic [1:0]  alu_src_EX,
  output logic        gpio_out_EX,
  output logic        gpio_in_EX,
  output logic        illegal_EX,
  output logic        valid_EX,
  output logic        hilo_busy,
  output logic        stall_req
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;

  if ((2 ** CNT_W) <= MAX_LAT) begin : g_cnt_w_check
    $error("ctrl_decode_ex: CNT_W too narrow for MUL_LAT/DIV_LAT");
  end

  ctrl_bundle_t dec_ctrl;
  ctrl_bundle_t ex_q;
  logic         dec_muldiv;
  logic         dec_hilo_read;
  hilo_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_load;
  logic         load_ex;
  logic         start_hilo;

  ctrl_decode u_decode (
    .instr        (instr_ID),
    .ctrl         (dec_ctrl),
    .is_muldiv    (dec_muldiv),
    .is_hilo_read (dec_hilo_read)
  );

  assign hilo_busy  = (cnt_q != '0);
  assign stall_req  = hilo_busy && valid_ID && (dec_muldiv || dec_hilo_read);
  assign load_ex    = !flush_in && !stall_in && !stall_req && valid_ID;
  assign start_hilo = load_ex && dec_muldiv;

`ifdef CTRL_DIV_EN
  assign lat_load = (dec_ctrl.alu_op == ALU_DIV || dec_ctrl.alu_op == ALU_DIVU)
                    ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
`else
  assign lat_load = CNT_W'(MUL_LAT);
`endif

  // Interlock state and occupancy counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a captured mul/div loads the counter; flushes never clear it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_hilo) begin
          cnt_d   = lat_load;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // EX register: flush > stall_in hold > interlock bubble > capture > bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ex_q <= CTRL_BUBBLE;
    else if (flush_in)       ex_q <= CTRL_BUBBLE;
    else if (stall_in)       ex_q <= ex_q;
    else if (stall_req)      ex_q <= CTRL_BUBBLE;
    else if (valid_ID)       ex_q <= dec_ctrl;
    else                     ex_q <= CTRL_BUBBLE;
  end

  assign alu_op_EX   = ex_q.alu_op;
  assign shamt_EX    = ex_q.shamt;
  assign enhilo_EX   = ex_q.enhilo;
  assign regsel_EX   = ex_q.regsel;
  assign regwrite_EX = ex_q.regwrite;
  assign rdrt_EX     = ex_q.rdrt;
  assign memwrite_EX = ex_q.memwrite;
  assign alu_src_EX  = ex_q.alu_src;
  assign gpio_out_EX = ex_q.gpio_out;
  assign gpio_in_EX  = ex_q.gpio_in;
  assign illegal_EX  = ex_q.illegal;
  assign valid_EX    = ex_q.valid;

endmodule

// File: tb/tb_ctrl_decode_ex.sv
// Scoreboard bench for ctrl_decode_ex (MUL_LAT=4, DIV_LAT=32).
module tb_ctrl_decode_ex;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_ID = '0;
  logic        valid_ID = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [3:0]  alu_op_EX;
  logic [4:0]  shamt_EX;
  logic        enhilo_EX;
  logic [1:0]  regsel_EX;
  logic        regwrite_EX;
  logic        rdrt_EX;
  logic        memwrite_EX;
  logic [1:0]  alu_src_EX;
  logic        gpio_out_EX;
  logic        gpio_in_EX;
  logic        illegal_EX;
  logic        valid_EX;
  logic        hilo_busy;
  logic        stall_req;

  always #5 clk = ~clk;

  ctrl_decode_ex #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .instr_ID(instr_ID), .valid_ID(valid_ID),
    .stall_in(stall_in), .flush_in(flush_in),
    .alu_op_EX(alu_op_EX), .shamt_EX(shamt_EX), .enhilo_EX(enhilo_EX),
    .regsel_EX(regsel_EX), .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX),
    .memwrite_EX(memwrite_EX), .alu_src_EX(alu_src_EX),
    .gpio_out_EX(gpio_out_EX), .gpio_in_EX(gpio_in_EX),
    .illegal_EX(illegal_EX), .valid_EX(valid_EX),
    .hilo_busy(hilo_busy), .stall_req(stall_req)
  );

  logic [20:0] got_vec;
  assign got_vec = {alu_op_EX, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX,
                    rdrt_EX, memwrite_EX, alu_src_EX, gpio_out_EX, gpio_in_EX,
                    illegal_EX, valid_EX};

  typedef struct packed {
    logic [20:0] vec;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected live bundle; memwrite is always 0, valid always 1.
  function automatic logic [20:0] mk(input logic [3:0] alu, input logic [4:0] sh,
                                     input logic eh, input logic [1:0] rs,
                                     input logic rw, input logic rr,
                                     input logic [1:0] src, input logic go,
                                     input logic gi, input logic ill);
    return {alu, sh, eh, rs, rw, rr, 1'b0, src, go, gi, ill, 1'b1};
  endfunction

  // Drive one cycle of ID inputs, check stall_req before the edge, then
  // compare the registered bundle one clock later against the scoreboard.
  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic st, input logic fl, input logic [20:0] exp_vec,
                      input logic exp_busy, input logic exp_sreq);
    exp_t e;
    instr_ID = ins; valid_ID = v; stall_in = st; flush_in = fl;
    e.vec = exp_vec; e.busy = exp_busy;
    sb.push_back(e);
    #2;
    check({tag, "/stall_req"}, 32'(stall_req), 32'(exp_sreq));
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, "/sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check(tag, 32'(got_vec), 32'(e.vec));
      check({tag, "/busy"}, 32'(hilo_busy), 32'(e.busy));
    end
  endtask

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ADDI = 32'h2001_0005;
  localparam logic [31:0] I_LUI  = 32'h3C01_ABCD;
  localparam logic [31:0] I_SRL0 = 32'h0001_1002;
  localparam logic [31:0] I_SRA0 = 32'h0001_1003;
  localparam logic [31:0] I_SLL4 = 32'h0001_1100;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;
  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_ORI  = 32'h3421_0F0F;
  localparam logic [31:0] I_SLTI = 32'h2822_0010;
  localparam logic [31:0] I_MULT = 32'h0022_0018;
  localparam logic [31:0] I_MFLO = 32'h0000_2012;
  localparam logic [31:0] I_MFHI = 32'h0000_2010;
  localparam logic [31:0] I_DIV  = 32'h0022_001A;

  logic [20:0] v_nop, v_addi, v_lui, v_srl0, v_sra0, v_sll4, v_ill, v_add;
  logic [20:0] v_ori, v_slti, v_mult, v_mflo, v_mfhi, v_div;
  logic [20:0] bub;

  initial begin
    bub    = '0;
    v_nop  = 21'h1;
    v_addi = mk(4'h4, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    v_lui  = mk(4'h8, 5'd16, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    v_srl0 = mk(4'h9, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    v_sra0 = mk(4'hA, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    v_sll4 = mk(4'h8, 5'd4, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    v_ill  = mk(4'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    v_add  = mk(4'h4, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    v_ori  = mk(4'h1, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    v_slti = mk(4'hC, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    v_mult = mk(4'h6, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    v_mflo = mk(4'h8, 5'd0, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    v_mfhi = mk(4'h8, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef CTRL_DIV_EN
    v_div  = mk(4'hE, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
`else
    v_div  = v_ill;
`endif

    // Reset state
    #12;
    check("reset/bundle", 32'(got_vec), 32'(0));
    check("reset/busy", 32'(hilo_busy), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Decode sweep
    step("nop",  I_NOP,  1'b1, 1'b0, 1'b0, v_nop,  1'b0, 1'b0);
    step("addi", I_ADDI, 1'b1, 1'b0, 1'b0, v_addi, 1'b0, 1'b0);
    step("lui",  I_LUI,  1'b1, 1'b0, 1'b0, v_lui,  1'b0, 1'b0);
    step("srl0", I_SRL0, 1'b1, 1'b0, 1'b0, v_srl0, 1'b0, 1'b0);
    step("sra0", I_SRA0, 1'b1, 1'b0, 1'b0, v_sra0, 1'b0, 1'b0);
    step("sll4", I_SLL4, 1'b1, 1'b0, 1'b0, v_sll4, 1'b0, 1'b0);
    step("ill",  I_ILL,  1'b1, 1'b0, 1'b0, v_ill,  1'b0, 1'b0);
    step("ori",  I_ORI,  1'b1, 1'b0, 1'b0, v_ori,  1'b0, 1'b0);
    step("slti", I_SLTI, 1'b1, 1'b0, 1'b0, v_slti, 1'b0, 1'b0);
    step("novalid", I_ADD, 1'b0, 1'b0, 1'b0, bub, 1'b0, 1'b0);

    // mult then mflo: four hazard cycles, four bubbles
    step("mult", I_MULT, 1'b1, 1'b0, 1'b0, v_mult, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("mflo_hold", I_MFLO, 1'b1, 1'b0, 1'b0, bub, (i < 3), 1'b1);
    step("mflo_issue", I_MFLO, 1'b1, 1'b0, 1'b0, v_mflo, 1'b0, 1'b0);

    // stall_in hold, then flush beats stall
    step("add", I_ADD, 1'b1, 1'b0, 1'b0, v_add, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall_hold", I_ORI, 1'b1, 1'b1, 1'b0, v_add, 1'b0, 1'b0);
    step("flush_stall", I_ORI, 1'b1, 1'b1, 1'b1, bub, 1'b0, 1'b0);

    // Flush in the mult capture cycle cancels the counter load
    step("mult_flush", I_MULT, 1'b1, 1'b0, 1'b1, bub, 1'b0, 1'b0);
    step("mfhi_nostall", I_MFHI, 1'b1, 1'b0, 1'b0, v_mfhi, 1'b0, 1'b0);

    // Flush while busy keeps counting; then async reset mid-BUSY
    step("mult2", I_MULT, 1'b1, 1'b0, 1'b0, v_mult, 1'b1, 1'b0);
    step("flush_busy", I_MFLO, 1'b1, 1'b0, 1'b1, bub, 1'b1, 1'b1);
    step("mflo_wait", I_MFLO, 1'b1, 1'b0, 1'b0, bub, 1'b1, 1'b1);
    #2; rst = 1'b1;
    #1;
    check("async_rst/bundle", 32'(got_vec), 32'(0));
    check("async_rst/busy", 32'(hilo_busy), 32'(0));
    check("async_rst/stall_req", 32'(stall_req), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    step("nop_after_rst", I_NOP, 1'b1, 1'b0, 1'b0, v_nop, 1'b0, 1'b0);
    step("mfhi_after_rst", I_MFHI, 1'b1, 1'b0, 1'b0, v_mfhi, 1'b0, 1'b0);

    // Divide
`ifdef CTRL_DIV_EN
    step("div", I_DIV, 1'b1, 1'b0, 1'b0, v_div, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++)
      step("div_hold", I_MFHI, 1'b1, 1'b0, 1'b0, bub, (i < 31), 1'b1);
    step("div_mfhi", I_MFHI, 1'b1, 1'b0, 1'b0, v_mfhi, 1'b0, 1'b0);
`else
    step("div_illegal", I_DIV, 1'b1, 1'b0, 1'b0, v_div, 1'b0, 1'b0);
    step("div_mfhi", I_MFHI, 1'b1, 1'b0, 1'b0, v_mfhi, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
